// File: rtl/direction_input_conditioner.sv
// Button front end for the snake game: synchronises and debounces four push-buttons and turns
// press events into a held one-hot direction that can never reverse 180 degrees.
module direction_input_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 320000,
    parameter int         CNT_WIDTH       = 19,
    parameter logic [1:0] INIT_DIR        = 2'b01
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iBtnWest,
    input  logic       iBtnEast,
    input  logic       iBtnNorth,
    input  logic       iBtnSouth,
    input  logic       iGameOver,
    output logic       oWest,
    output logic       oEast,
    output logic       oNorth,
    output logic       oSouth,
    output logic [1:0] oDirCode,
    output logic       oDirChange
);

    typedef enum logic [1:0] {
        DIR_WEST  = 2'b00,
        DIR_EAST  = 2'b01,
        DIR_NORTH = 2'b10,
        DIR_SOUTH = 2'b11
    } dir_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Button vectors are indexed by direction code so a bit index doubles as the code.
    localparam int W_IDX = 0;
    localparam int E_IDX = 1;
    localparam int N_IDX = 2;
    localparam int S_IDX = 3;

    logic [3:0]           raw;
    logic [3:0]           sync1;
    logic [3:0]           sync2;
    logic [3:0]           deb;
    logic [3:0]           deb_d;
    logic [3:0]           press;
    logic [CNT_WIDTH-1:0] cnt [4];

    dir_t                 state;
    dir_t                 cand;
    dir_t                 opposite;
    logic                 cand_valid;
    logic                 accept;
    logic [3:0]           dir_onehot;

    assign raw = {iBtnSouth, iBtnNorth, iBtnEast, iBtnWest};

    function automatic logic [3:0] decode_dir(input logic [1:0] code);
        logic [3:0] oh;
        oh       = 4'b0000;
        oh[code] = 1'b1;
        return oh;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Each debounced bit flips only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign press = deb & ~deb_d;

    always_comb begin
        cand_valid = 1'b0;
        cand       = DIR_EAST;
        if (press[N_IDX]) begin
            cand_valid = 1'b1;
            cand       = DIR_NORTH;
        end else if (press[S_IDX]) begin
            cand_valid = 1'b1;
            cand       = DIR_SOUTH;
        end else if (press[W_IDX]) begin
            cand_valid = 1'b1;
            cand       = DIR_WEST;
        end else if (press[E_IDX]) begin
            cand_valid = 1'b1;
            cand       = DIR_EAST;
        end
    end

    // Opposite pairs differ only in bit 0; a rejected candidate never falls back to a lower one.
    assign opposite = dir_t'(state ^ 2'b01);
    assign accept   = cand_valid && !iGameOver && (cand != state) && (cand != opposite);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= dir_t'(INIT_DIR);
            dir_onehot <= decode_dir(INIT_DIR);
            oDirChange <= 1'b0;
        end else begin
            oDirChange <= accept;
            if (accept) begin
                state      <= cand;
                dir_onehot <= decode_dir(cand);
            end
        end
    end

    assign oWest    = dir_onehot[W_IDX];
    assign oEast    = dir_onehot[E_IDX];
    assign oNorth   = dir_onehot[N_IDX];
    assign oSouth   = dir_onehot[S_IDX];
    assign oDirCode = state;

endmodule

// File: tb/tb_direction_input_conditioner.sv
// Directed bench for direction_input_conditioner with a short debounce window; every
// expected direction and strobe is hand-derived and checked with immediate assertions.
module tb_direction_input_conditioner;

    localparam int         D    = 4;
    localparam logic [1:0] C_W  = 2'b00;
    localparam logic [1:0] C_E  = 2'b01;
    localparam logic [1:0] C_N  = 2'b10;
    localparam logic [1:0] C_S  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_w;
    logic       btn_e;
    logic       btn_n;
    logic       btn_s;
    logic       game_over;
    logic       o_w;
    logic       o_e;
    logic       o_n;
    logic       o_s;
    logic [1:0] dir_code;
    logic       dir_change;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    direction_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (3),
        .INIT_DIR       (2'b01)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .iBtnWest  (btn_w),
        .iBtnEast  (btn_e),
        .iBtnNorth (btn_n),
        .iBtnSouth (btn_s),
        .iGameOver (game_over),
        .oWest     (o_w),
        .oEast     (o_e),
        .oNorth    (o_n),
        .oSouth    (o_s),
        .oDirCode  (dir_code),
        .oDirChange(dir_change)
    );

    // Expected {W,E,N,S one-hot, code, strobe} for a given direction code.
    function automatic logic [6:0] expect_vec(input logic [1:0] code, input logic chg);
        logic [3:0] oh;
        case (code)
            2'b00:   oh = 4'b1000;
            2'b01:   oh = 4'b0100;
            2'b10:   oh = 4'b0010;
            default: oh = 4'b0001;
        endcase
        return {oh, code, chg};
    endfunction

    task automatic check(input string tag, input logic [1:0] code, input logic chg);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {o_w, o_e, o_n, o_s, dir_code, dir_change};
        exp = expect_vec(code, chg);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed WENS/code/chg=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step_check(input int n, input string tag, input logic [1:0] code,
                              input logic chg);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(tag, code, chg);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_pulse", C_E, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        btn_w     = 1'b0;
        btn_e     = 1'b0;
        btn_n     = 1'b0;
        btn_s     = 1'b0;
        game_over = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", C_E, 1'b0);
        rst = 1'b0;

        // A level driven just after edge e reaches sync2 at e+2; the strobe lands D+1 edges later.
        btn_n = 1'b1;
        step_check(D + 2, "north_wait", C_E, 1'b0);
        step_check(1, "north_accept", C_N, 1'b1);
        step_check(6, "north_hold", C_N, 1'b0);
        btn_n = 1'b0;
        step_check(8, "north_release", C_N, 1'b0);

        // Bounce on South: 3 high, 1 low, 2 high never reaches D consecutive samples.
        do_reset();
        btn_s = 1'b1;
        step_check(3, "bounce_hi3", C_E, 1'b0);
        btn_s = 1'b0;
        step_check(1, "bounce_lo1", C_E, 1'b0);
        btn_s = 1'b1;
        step_check(2, "bounce_hi2", C_E, 1'b0);
        btn_s = 1'b0;
        step_check(10, "bounce_settle", C_E, 1'b0);
        btn_s = 1'b1;
        step_check(D + 2, "south_wait", C_E, 1'b0);
        step_check(1, "south_accept", C_S, 1'b1);
        btn_s = 1'b0;
        step_check(8, "south_release", C_S, 1'b0);

        // Reversals are refused; a perpendicular turn is taken.
        do_reset();
        btn_w = 1'b1;
        step_check(12, "west_reversal", C_E, 1'b0);
        btn_w = 1'b0;
        step_check(8, "west_release", C_E, 1'b0);
        btn_n = 1'b1;
        step_check(D + 2, "turn_north_wait", C_E, 1'b0);
        step_check(1, "turn_north_accept", C_N, 1'b1);
        btn_n = 1'b0;
        step_check(8, "turn_north_release", C_N, 1'b0);
        btn_s = 1'b1;
        step_check(12, "south_reversal", C_N, 1'b0);
        btn_s = 1'b0;
        step_check(8, "south_rev_release", C_N, 1'b0);

        // Simultaneous presses resolve by priority North > South > West > East.
        do_reset();
        btn_n = 1'b1;
        btn_w = 1'b1;
        step_check(D + 2, "nw_wait", C_E, 1'b0);
        step_check(1, "nw_accept_north", C_N, 1'b1);
        step_check(2, "nw_single_pulse", C_N, 1'b0);
        btn_n = 1'b0;
        btn_w = 1'b0;
        step_check(8, "nw_release", C_N, 1'b0);
        do_reset();
        btn_w = 1'b1;
        btn_s = 1'b1;
        step_check(D + 2, "ws_wait", C_E, 1'b0);
        step_check(1, "ws_accept_south", C_S, 1'b1);
        step_check(2, "ws_single_pulse", C_S, 1'b0);
        btn_w = 1'b0;
        btn_s = 1'b0;
        step_check(8, "ws_release", C_S, 1'b0);
        // North beats East but reverses South; East must not be taken as a fallback.
        btn_n = 1'b1;
        btn_e = 1'b1;
        step_check(12, "ne_no_fallback", C_S, 1'b0);
        btn_n = 1'b0;
        btn_e = 1'b0;
        step_check(8, "ne_release", C_S, 1'b0);

        // A press that completes during game over is lost, not queued.
        do_reset();
        game_over = 1'b1;
        btn_n     = 1'b1;
        step_check(12, "gameover_hold", C_E, 1'b0);
        game_over = 1'b0;
        step_check(8, "gameover_cleared", C_E, 1'b0);
        btn_n = 1'b0;
        step_check(8, "gameover_release", C_E, 1'b0);
        btn_n = 1'b1;
        step_check(D + 2, "after_go_wait", C_E, 1'b0);
        step_check(1, "after_go_accept", C_N, 1'b1);
        step_check(1, "after_go_hold", C_N, 1'b0);

        // One-cycle reset with North held: back to East, then North debounces in afresh.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_midpress", C_E, 1'b0);
        rst = 1'b0;
        step_check(D + 2, "repress_wait", C_E, 1'b0);
        step_check(1, "repress_accept", C_N, 1'b1);
        step_check(2, "repress_hold", C_N, 1'b0);
        btn_n = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
